cisc_exec_core: RTL

Parametrised successor to the 8-bit single-opcode ALU stage: a register-file execution core with a valid/ready instruction input, a valid/ready result output, condition flags, and an iterative multi-cycle multiply. It sits between the instruction decoder and the writeback/retire logic. It executes one instruction at a time and commits the result to an internal register file before the result is presented.

---
 rtl/cisc_pkg.sv | 37 +++
 rtl/cisc_alu_comb.sv | 74 +++++++
 rtl/cisc_exec_core.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cisc_pkg.sv
// cisc_pkg: shared definitions for the execution core.
//   - opcode encodings
//   - FSM state enum
//   - flag bit positions in out_flags ({Z,N,C,V})
//   - helper that tells whether an opcode commits to the register file
package cisc_pkg;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_NOT = 8'h05;
  localparam logic [7:0] OP_SHL = 8'h06;
  localparam logic [7:0] OP_SHR = 8'h07;
  localparam logic [7:0] OP_MOV = 8'h08;
  localparam logic [7:0] OP_MUL = 8'h09;
  localparam logic [7:0] OP_CMP = 8'h0A;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_DONE
  } state_t;

  // Opcodes 00..09 are contiguous and all write rd; CMP and illegal ones do not.
  function automatic logic op_writes_rd(input logic [7:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/cisc_alu_comb.sv
// cisc_alu_comb: combinational single-cycle operations and flag generation.
// Ports:
//   opcode  in   8       operation
//   src1    in   DATA_W  first operand
//   src2    in   DATA_W  second operand (register or immediate)
//   result  out  DATA_W  operation result (0 for MUL, which is sequenced elsewhere)
//   flags   out  4       {Z,N,C,V}; all 0 for an illegal opcode
//   illegal out  1       opcode is undefined
module cisc_alu_comb
  import cisc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [7:0]        opcode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic              illegal
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;
  logic            carry;
  logic            ovf;

  assign sum_ext  = {1'b0, src1} + {1'b0, src2};
  // Top bit of the extended difference is the unsigned borrow.
  assign diff_ext = {1'b0, src1} - {1'b0, src2};

  always_comb begin
    result  = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    flags   = '0;
    case (opcode)
      OP_ADD: begin
        result = sum_ext[MSB:0];
        carry  = sum_ext[DATA_W];
        ovf    = (src1[MSB] == src2[MSB]) && (sum_ext[MSB] != src1[MSB]);
      end
      OP_SUB, OP_CMP: begin
        result = diff_ext[MSB:0];
        carry  = diff_ext[DATA_W];
        ovf    = (src1[MSB] != src2[MSB]) && (diff_ext[MSB] != src1[MSB]);
      end
      OP_AND: result = src1 & src2;
      OP_OR:  result = src1 | src2;
      OP_XOR: result = src1 ^ src2;
      OP_NOT: result = ~src1;
      OP_SHL: begin
        result = {src1[MSB-1:0], 1'b0};
        carry  = src1[MSB];
      end
      OP_SHR: begin
        result = {1'b0, src1[MSB:1]};
        carry  = src1[0];
      end
      OP_MOV: result = src2;
      OP_MUL: result = '0;
      default: illegal = 1'b1;
    endcase
    if (!illegal) begin
      flags[FLG_Z] = (result == '0);
      flags[FLG_N] = result[MSB];
      flags[FLG_C] = carry;
      flags[FLG_V] = ovf;
    end
  end

endmodule

// File: rtl/cisc_exec_core.sv
// cisc_exec_core: register-file execution core, one instruction in flight.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        instruction handshake (ready only in IDLE)
//   in_opcode                operation
//   in_rd/in_rs1/in_rs2      register indices
//   in_imm, in_imm_sel       immediate and src2 select (1 = immediate)
//   out_valid/out_ready      result handshake (valid only in DONE)
//   out_result, out_flags    result and {Z,N,C,V}
//   out_illegal              opcode was undefined
//
// state   | meaning
// IDLE    | waiting for an instruction, operands latched on accept
// EXEC    | single-cycle op computed, committed and registered
// MUL     | shift-add multiply, one multiplier bit per cycle
// DONE    | result presented and held until out_ready
module cisc_exec_core
  import cisc_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int REG_N  = 16,
  localparam int RA_W   = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_opcode,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_imm_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic              out_illegal
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t              state;
  logic [7:0]          op_q;
  logic [RA_W-1:0]     rd_q;
  logic [DATA_W-1:0]   src1_q;
  logic [DATA_W-1:0]   src2_q;
  logic [2*DATA_W-1:0] mcand_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [DATA_W-1:0]   regs [REG_N];

  logic [DATA_W-1:0]   rd_src1;
  logic [DATA_W-1:0]   rd_src2;
  logic [DATA_W-1:0]   alu_result;
  logic [3:0]          alu_flags;
  logic                alu_illegal;
  logic [2*DATA_W-1:0] acc_next;
  logic                mul_last;
  logic [DATA_W-1:0]   mul_result;
  logic [3:0]          mul_flags;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;

  assign rd_src1 = regs[in_rs1];
  assign rd_src2 = in_imm_sel ? in_imm : regs[in_rs2];

  cisc_alu_comb #(.DATA_W(DATA_W)) u_alu (
    .opcode  (op_q),
    .src1    (src1_q),
    .src2    (src2_q),
    .result  (alu_result),
    .flags   (alu_flags),
    .illegal (alu_illegal)
  );

  // src2_q is shifted right each iteration, so its bit 0 is the current multiplier bit.
  assign acc_next   = acc_q + (src2_q[0] ? mcand_q : '0);
  assign mul_last   = (state == ST_MUL) && (cnt_q == '0);
  assign mul_result = acc_next[DATA_W-1:0];

  always_comb begin
    mul_flags        = '0;
    mul_flags[FLG_Z] = (mul_result == '0);
    mul_flags[FLG_N] = mul_result[DATA_W-1];
    mul_flags[FLG_C] = |acc_next[2*DATA_W-1:DATA_W];
  end

  assign wr_en   = ((state == ST_EXEC) && op_writes_rd(op_q)) || mul_last;
  assign wr_data = (state == ST_MUL) ? mul_result : alu_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_flags   <= '0;
      out_illegal <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= in_opcode;
            rd_q     <= in_rd;
            src1_q   <= rd_src1;
            src2_q   <= rd_src2;
            mcand_q  <= {{DATA_W{1'b0}}, rd_src1};
            acc_q    <= '0;
            cnt_q    <= CNT_W'(DATA_W - 1);
            in_ready <= 1'b0;
            state    <= (in_opcode == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_result  <= alu_result;
          out_flags   <= alu_flags;
          out_illegal <= alu_illegal;
          out_valid   <= 1'b1;
          state       <= ST_DONE;
        end
        ST_MUL: begin
          acc_q   <= acc_next;
          mcand_q <= mcand_q << 1;
          src2_q  <= src2_q >> 1;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            out_result  <= mul_result;
            out_flags   <= mul_flags;
            out_illegal <= 1'b0;
            out_valid   <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
